axis_pattern_generator: RTL and testbench

Parametrised AXI4-Stream test source. It is the successor to the fixed counter generator and runs on the same master-side clock. A runtime-programmable rate divider issues sample credits into a bounded virtual FIFO. On each accepted beat the block emits one of four data patterns (counter, PRBS, walking-one, constant), framed into fixed-length packets. Overflow is detected and counted when the sink cannot keep up.

---
 rtl/axis_pattern_pkg.sv | 29 ++
 rtl/axis_pattern_rate_gen.sv | 24 ++
 rtl/axis_pattern_generator.sv | 110 +++++++++++
 tb/tb_axis_pattern_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_pkg.sv
// axis_pattern_pkg: mode encoding, credit-counter width helper and seed selection shared by the generator.
package axis_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_PRBS    = 2'd1,
        MODE_WALK    = 2'd2,
        MODE_CONST   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEED_START = 2'd0,
        SEED_LFSR  = 2'd1,
        SEED_ONE   = 2'd2
    } seed_e;

    localparam int DEFAULT_CREDIT_DEPTH = 16;
    localparam int DEFAULT_CREDIT_W     = $clog2(DEFAULT_CREDIT_DEPTH + 1);

    // Credits span 0..depth inclusive, hence depth+1 states.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic seed_e seed_sel(input mode_e m);
        return m == MODE_PRBS ? SEED_LFSR : m == MODE_WALK ? SEED_ONE : SEED_START;
    endfunction

endpackage

// File: rtl/axis_pattern_rate_gen.sv
// axis_pattern_rate_gen: programmable period divider producing one-cycle sample ticks.
module axis_pattern_rate_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] divctr_q, divctr_d;

    // A divider of 0 reloads like 1, so both give a tick every cycle.
    assign divctr_d = divctr_q != '0 ? divctr_q - 1'b1 :
                      divider_i == '0 ? '0 : divider_i - 1'b1;
    assign tick_o   = (divctr_q == '0) & enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) divctr_q <= '0;
        else       divctr_q <= divctr_d;
    end

endmodule

// File: rtl/axis_pattern_generator.sv
// axis_pattern_generator: AXI4-Stream test source with rate-limited credits, four data patterns,
// fixed-length packet framing and overflow accounting.
module axis_pattern_generator
    import axis_pattern_pkg::*;
#(
    parameter int                     TDATA_WIDTH   = 32,
    parameter int                     BURSTSIZE     = 16,
    parameter int                     COUNTER_START = 0,
    parameter int                     COUNTER_END   = 255,
    parameter int                     COUNTER_INCR  = 1,
    parameter logic [TDATA_WIDTH-1:0] LFSR_POLY     = TDATA_WIDTH'(32'h80200003),
    parameter logic [TDATA_WIDTH-1:0] LFSR_SEED     = TDATA_WIDTH'(1),
    parameter int                     DIV_WIDTH     = 16,
    parameter int                     CREDIT_DEPTH  = 16,
    parameter int                     DROP_WIDTH    = 16
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_areset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   divider,
    input  logic                   clear_status,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    localparam int CW = credit_width(CREDIT_DEPTH);
    localparam int BW = BURSTSIZE > 1 ? $clog2(BURSTSIZE) : 1;
    localparam logic [CW-1:0]          FULL      = CW'(CREDIT_DEPTH);
    localparam logic [BW-1:0]          LAST_BEAT = BW'(BURSTSIZE - 1);
    localparam logic [TDATA_WIDTH-1:0] START     = TDATA_WIDTH'(COUNTER_START);
    localparam logic [TDATA_WIDTH-1:0] INCR      = TDATA_WIDTH'(COUNTER_INCR);
    localparam logic [TDATA_WIDTH-1:0] WRAP_AT   = TDATA_WIDTH'(COUNTER_END - COUNTER_INCR + 1);
    localparam logic [TDATA_WIDTH-1:0] WRAP_STEP = TDATA_WIDTH'(COUNTER_INCR - (COUNTER_END - COUNTER_START) - 1);
    localparam logic [TDATA_WIDTH-1:0] ONE       = TDATA_WIDTH'(1);

    logic                   tick, accept, drop, last, reload;
    logic [CW-1:0]          credits_q, credits_d;
    logic                   tvalid_q, tvalid_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d, next_val, seed_val;
    mode_e                  mode_q, mode_d, mode_new;
    logic                   overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0]  drop_q, drop_d;

    axis_pattern_rate_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rate (
        .clk_i     (m_axis_aclk),
        .rst_i     (m_axis_areset),
        .enable_i  (enable),
        .divider_i (divider),
        .tick_o    (tick)
    );

    assign accept   = tvalid_q & m_axis_tready;
    assign last     = tvalid_q & (beat_q == LAST_BEAT);
    assign drop     = tick & ~accept & (credits_q == FULL);
    assign mode_new = mode_e'(mode);

    assign credits_d  = (tick & ~accept & (credits_q != FULL)) ? credits_q + 1'b1 :
                        (accept & ~tick) ? credits_q - 1'b1 : credits_q;
    assign tvalid_d   = credits_d != '0;
    assign beat_d     = accept ? (beat_q == LAST_BEAT ? '0 : beat_q + 1'b1) : beat_q;
    // Clear wins over the old sticky state, but a drop in the same cycle still registers.
    assign overflow_d = drop | (overflow_q & ~clear_status);
    assign drop_d     = clear_status ? DROP_WIDTH'(drop) :
                        (drop & ~&drop_q) ? drop_q + 1'b1 : drop_q;

    always_comb begin
        next_val = mode_q == MODE_COUNTER ? (tdata_q >= WRAP_AT ? tdata_q + WRAP_STEP : tdata_q + INCR) :
                   mode_q == MODE_PRBS    ? (tdata_q >> 1) ^ (tdata_q[0] ? LFSR_POLY : '0) :
                   mode_q == MODE_WALK    ? {tdata_q[TDATA_WIDTH-2:0], tdata_q[TDATA_WIDTH-1]} : START;
        seed_val = seed_sel(mode_new) == SEED_LFSR ? LFSR_SEED :
                   seed_sel(mode_new) == SEED_ONE  ? ONE : START;
        // Mode may only change on a packet boundary: the tlast accept, or idle at packet start.
        reload   = (mode_new != mode_q) & ((accept & last) | (~tvalid_q & (beat_q == '0)));
        mode_d   = reload ? mode_new : mode_q;
        tdata_d  = reload ? seed_val : accept ? next_val : tdata_q;
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            credits_q  <= '0;
            tvalid_q   <= 1'b0;
            beat_q     <= '0;
            tdata_q    <= START;
            mode_q     <= MODE_COUNTER;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            credits_q  <= credits_d;
            tvalid_q   <= tvalid_d;
            beat_q     <= beat_d;
            tdata_q    <= tdata_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = last;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_pattern_generator.sv
// tb_axis_pattern_generator: randomized stimulus against a behavioural model with a beat scoreboard.
module tb_axis_pattern_generator;

    localparam int          BURST = 16;
    localparam int          DEPTH = 16;
    localparam int          START = 0;
    localparam int          CEND  = 255;
    localparam int          INCR  = 1;
    localparam logic [31:0] POLY  = 32'h80200003;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, clear, tready;
    logic [1:0]  mode;
    logic [15:0] divider;
    logic [31:0] tdata, tdata1;
    logic        tvalid, tlast, overflow, tvalid1, tlast1, overflow1;
    logic [15:0] drop_count, drop1;

    axis_pattern_generator dut (
        .m_axis_aclk(clk), .m_axis_areset(rst), .enable(enable), .mode(mode), .divider(divider),
        .clear_status(clear), .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .overflow(overflow), .drop_count(drop_count)
    );

    axis_pattern_generator #(.BURSTSIZE(1)) dut1 (
        .m_axis_aclk(clk), .m_axis_areset(rst), .enable(enable), .mode(mode), .divider(divider),
        .clear_status(clear), .m_axis_tready(tready), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tlast(tlast1), .overflow(overflow1), .drop_count(drop1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] data; bit last; } beat_t;
    beat_t exp_q[$];

    int          m_wait, m_credits, m_beat, m_drops, m_mode;
    bit          m_valid, m_ovf, m_acc;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed_of(input int md);
        return md == 1 ? 32'd1 : md == 2 ? 32'd1 : 32'(START);
    endfunction

    function automatic logic [31:0] step(input int md, input logic [31:0] d);
        case (md)
            0:       return 32'(START) + (d - 32'(START) + 32'(INCR)) % 32'(CEND - START + 1);
            1:       return d[0] ? (d >> 1) ^ POLY : d >> 1;
            2:       return {d[30:0], d[31]};
            default: return 32'(START);
        endcase
    endfunction

    task automatic model_reset();
        m_wait = 0; m_credits = 0; m_beat = 0; m_drops = 0; m_mode = 0;
        m_valid = 0; m_ovf = 0; m_acc = 0; m_data = 32'(START);
        exp_q.delete();
    endtask

    // Applies one clock edge to the model, using the inputs the DUT sampled at that edge.
    task automatic model_edge();
        bit tick, drop;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_valid && m_beat == 0 && int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_data = seed_of(m_mode);
        end
        tick   = (m_wait == 0) && enable;
        m_wait = (m_wait == 0) ? ((divider > 1) ? int'(divider) - 1 : 0) : m_wait - 1;
        drop   = tick && !m_acc && m_credits == DEPTH;
        if (tick && !m_acc && !drop) m_credits++;
        else if (m_acc && !tick) m_credits--;
        if (clear) begin
            m_ovf   = drop;
            m_drops = drop ? 1 : 0;
        end else begin
            m_ovf = m_ovf | drop;
            if (drop && m_drops < 65535) m_drops++;
        end
        m_valid = m_credits != 0;
        m_acc   = 0;
    endtask

    // Decides whether the beat on offer will be taken and records what it must carry.
    task automatic model_issue();
        bit last;
        m_acc = m_valid && tready && !rst;
        if (m_acc) begin
            last = (m_beat == BURST - 1);
            exp_q.push_back('{m_data, last});
            if (last && int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_data = seed_of(m_mode);
            end else begin
                m_data = step(m_mode, m_data);
            end
            m_beat = last ? 0 : m_beat + 1;
        end
    endtask

    task automatic cycle(input bit r, input bit en, input logic [1:0] md, input logic [15:0] dv,
                         input bit rdy, input bit clr);
        @(posedge clk);
        model_edge();
        #2;
        rst = r; enable = en; mode = md; divider = dv; tready = rdy; clear = clr;
        model_issue();
    endtask

    beat_t got;
    always @(negedge clk) begin
        if (!rst) begin
            check("tvalid", 64'(tvalid), 64'(m_valid));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("drop_count", 64'(drop_count), 64'(m_drops));
            check("b1_tvalid", 64'(tvalid1), 64'(m_valid));
            check("b1_tlast", 64'(tlast1), 64'(tvalid1));
            check("b1_drop_count", 64'(drop1), 64'(m_drops));
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: got unexpected beat tdata=%0h expected no beat at %0t", tdata, $time);
                end else begin
                    got = exp_q.pop_front();
                    check("tdata", 64'(tdata), 64'(got.data));
                    check("tlast", 64'(tlast), 64'(got.last));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_tdata"}, 64'(tdata), 64'(START));
        check({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(tlast), 64'd0);
    endtask

    initial begin
        logic [1:0] md;
        rst = 1; enable = 0; mode = 0; divider = 1; tready = 0; clear = 0;
        model_reset();
        repeat (3) cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check_reset_outputs("reset");
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);

        repeat (300) cycle(0, 1, 0, 1, 1, 0);
        repeat (7) cycle(0, 1, 0, 1, 1, 0);
        cycle(1, 1, 0, 1, 1, 0);
        cycle(0, 1, 0, 1, 1, 0);
        check_reset_outputs("midreset");

        repeat (100) cycle(0, 1, 0, 0, 1, 0);

        repeat (100) cycle(0, 1, 0, 4, 0, 0);
        @(negedge clk);
        #1;
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_full_valid", 64'(tvalid), 64'd1);
        cycle(0, 1, 0, 4, 0, 1);
        repeat (80) cycle(0, 1, 0, 4, 0, $urandom_range(0, 7) == 0);
        repeat (30) cycle(0, 0, 0, 1, 1, 1);

        repeat (1400) cycle(0, 1, 1, 1, $urandom_range(0, 3) != 0, 0);
        repeat (5) cycle(0, 1, 0, 1, 1, 0);
        repeat (300) cycle(0, 1, 2, 1, $urandom_range(0, 1) == 1, 0);

        md = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
            cycle(0, $urandom_range(0, 3) != 0, md, 16'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end

        repeat (40) cycle(0, 0, md, 1, 1, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
